// File: rtl/ctrl_pipe_n.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_n
//
// Parametrised control-signal pipeline for the pipelined ARM core. Carries
// the decoded control bundle from Decode (stage 0) through STAGES-1
// registered stages, evaluates the ARM condition field in Execute (stage 1)
// against an internal NZCV register, gates the side-effect bits of
// instructions whose condition fails and produces the Execute branch strobe.
//
// Parameters:
//   STAGES  total stages including Decode, legal range 3..8
//   CTRL_W  bundle width, legal minimum 6. Layout:
//           bit0 RegWrite, bit1 MemWrite, bit2 PCSrc, bit3 Branch,
//           bit4 FlagWrite[0] (C,V), bit5 FlagWrite[1] (N,Z),
//           bits CTRL_W-1:6 opaque payload
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   ctrl_d          decoded bundle entering stage 1
//   cond_d          Instr[31:28] of the decoded instruction
//   valid_d         stage 0 holds a real instruction
//   stall           bit k-1 holds stage k
//   flush           bit k-1 loads a bubble into stage k
//   alu_flags_e     NZCV produced by the Execute ALU
//   ctrl_q          stage k bundle at [k*CTRL_W-1 -: CTRL_W]
//   valid_q         bit k-1 = stage k valid
//   flags_q         architectural NZCV register
//   cond_ex_e       stage-1 instruction passes its condition
//   branch_taken_e  stage-1 valid branch whose condition passes
//   perf_bubbles    (CTRL_PIPE_PERF_EN only) stage-1 bubble loads, saturating
//   perf_condfail   (CTRL_PIPE_PERF_EN only) condition-failed advances, saturating
//
// Build option: define CTRL_PIPE_PERF_EN to add the two performance counters.
// ---------------------------------------------------------------------------
module ctrl_pipe_n #(
    parameter int STAGES = 4,
    parameter int CTRL_W = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CTRL_W-1:0]              ctrl_d,
    input  logic [3:0]                     cond_d,
    input  logic                           valid_d,
    input  logic [STAGES-2:0]              stall,
    input  logic [STAGES-2:0]              flush,
    input  logic [3:0]                     alu_flags_e,
    output logic [CTRL_W*(STAGES-1)-1:0]   ctrl_q,
    output logic [STAGES-2:0]              valid_q,
    output logic [3:0]                     flags_q,
    output logic                           cond_ex_e,
    output logic                           branch_taken_e
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [15:0]                    perf_bubbles,
    output logic [15:0]                    perf_condfail
`endif
);

    localparam int NREG   = STAGES - 1;
    localparam int PIPE_W = CTRL_W * NREG;

    // Side-effect bits cleared when the condition fails: RegWrite, MemWrite,
    // PCSrc and both FlagWrite bits. Branch (bit3) and payload pass through.
    localparam logic [CTRL_W-1:0] GATE_MASK = CTRL_W'(6'b110111);

    // ARM condition-code evaluation; nzcv = {N, Z, C, V}.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            4'b1111: pass = 1'b0;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

`ifdef CTRL_PIPE_PERF_EN
    // Saturating 16-bit increment for the performance counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        logic [15:0] res;
        if (cnt == 16'hFFFF) begin
            res = cnt;
        end else begin
            res = cnt + 16'd1;
        end
        return res;
    endfunction
`endif

    logic [PIPE_W-1:0] ctrl_r;
    logic [PIPE_W-1:0] ctrl_nxt_s;
    logic [PIPE_W-1:0] feed_ctrl_s;
    logic [NREG-1:0]   valid_r;
    logic [NREG-1:0]   valid_nxt_s;
    logic [NREG-1:0]   feed_valid_s;
    logic [3:0]        cond_r;
    logic [3:0]        cond_nxt_s;
    logic [3:0]        flags_r;
    logic [3:0]        flags_nxt_s;
    logic [NREG:0]     eff_stall_s;
    logic [CTRL_W-1:0] ctrl1_s;
    logic [CTRL_W-1:0] gated1_s;
    logic              cond_pass_s;
    logic              cond_ex_s;
    logic              flag_upd_s;

    assign ctrl1_s     = ctrl_r[CTRL_W-1:0];
    assign cond_pass_s = cond_check(cond_r, flags_r);
    assign cond_ex_s   = valid_r[0] & cond_pass_s;

    // Effective stall: a stage is held when it or any later stage stalls.
    // Bit 0 is Decode, which is held whenever stage 1 is.
    always_comb begin
        eff_stall_s    = {(NREG + 1){1'b0}};
        eff_stall_s[0] = |stall;
        for (int k = 1; k <= NREG; k++) begin
            eff_stall_s[k] = |(stall >> (k - 1));
        end
    end

    // Condition gating of the stage-1 bundle on its way into stage 2.
    always_comb begin
        if (cond_ex_s) begin
            gated1_s = ctrl1_s;
        end else begin
            gated1_s = ctrl1_s & ~GATE_MASK;
        end
    end

    // Source of each stage: slot k holds what stage k would load on advance.
    always_comb begin
        feed_ctrl_s                         = {ctrl_r[PIPE_W-CTRL_W-1:0], ctrl_d};
        feed_ctrl_s[2*CTRL_W-1 -: CTRL_W]   = gated1_s;
        feed_valid_s                        = {valid_r[NREG-2:0], valid_d};
    end

    // Per-stage next value: flush, then hold, then bubble behind a stalled
    // predecessor, otherwise advance.
    always_comb begin
        ctrl_nxt_s  = ctrl_r;
        valid_nxt_s = valid_r;
        for (int k = 1; k <= NREG; k++) begin
            if (flush[k-1]) begin
                ctrl_nxt_s[k*CTRL_W-1 -: CTRL_W] = {CTRL_W{1'b0}};
                valid_nxt_s[k-1]                 = 1'b0;
            end else if (eff_stall_s[k]) begin
                ctrl_nxt_s[k*CTRL_W-1 -: CTRL_W] = ctrl_r[k*CTRL_W-1 -: CTRL_W];
                valid_nxt_s[k-1]                 = valid_r[k-1];
            end else if (eff_stall_s[k-1]) begin
                ctrl_nxt_s[k*CTRL_W-1 -: CTRL_W] = {CTRL_W{1'b0}};
                valid_nxt_s[k-1]                 = 1'b0;
            end else begin
                ctrl_nxt_s[k*CTRL_W-1 -: CTRL_W] = feed_ctrl_s[k*CTRL_W-1 -: CTRL_W];
                valid_nxt_s[k-1]                 = feed_valid_s[k-1];
            end
        end
    end

    // Stage-1 condition field follows the stage-1 bundle.
    always_comb begin
        if (flush[0]) begin
            cond_nxt_s = 4'b0000;
        end else if (eff_stall_s[1]) begin
            cond_nxt_s = cond_r;
        end else begin
            cond_nxt_s = cond_d;
        end
    end

    // Flags load only when a passing stage-1 instruction leaves Execute;
    // a stalled or flushed Execute slot never commits flags.
    always_comb begin
        flag_upd_s        = ~eff_stall_s[1] & ~flush[0] & cond_ex_s;
        flags_nxt_s[3:2]  = (flag_upd_s & ctrl1_s[5]) ? alu_flags_e[3:2] : flags_r[3:2];
        flags_nxt_s[1:0]  = (flag_upd_s & ctrl1_s[4]) ? alu_flags_e[1:0] : flags_r[1:0];
    end

    // Pipeline, condition and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r  <= {PIPE_W{1'b0}};
            valid_r <= {NREG{1'b0}};
            cond_r  <= 4'b0000;
            flags_r <= 4'b0000;
        end else begin
            ctrl_r  <= ctrl_nxt_s;
            valid_r <= valid_nxt_s;
            cond_r  <= cond_nxt_s;
            flags_r <= flags_nxt_s;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] perf_bub_r;
    logic [15:0] perf_cf_r;
    logic        bubble_ev_s;
    logic        condfail_ev_s;

    // Stage 1 only takes a predecessor-stall bubble if Decode could stall
    // alone; kept for symmetry with the later stages.
    assign bubble_ev_s   = flush[0] | (eff_stall_s[0] & ~eff_stall_s[1]);
    assign condfail_ev_s = valid_r[0] & ~cond_pass_s & ~eff_stall_s[1];

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bub_r <= 16'd0;
            perf_cf_r  <= 16'd0;
        end else begin
            perf_bub_r <= bubble_ev_s ? sat_inc(perf_bub_r) : perf_bub_r;
            perf_cf_r  <= condfail_ev_s ? sat_inc(perf_cf_r) : perf_cf_r;
        end
    end

    assign perf_bubbles  = perf_bub_r;
    assign perf_condfail = perf_cf_r;
`endif

    assign ctrl_q         = ctrl_r;
    assign valid_q        = valid_r;
    assign flags_q        = flags_r;
    assign cond_ex_e      = cond_ex_s;
    assign branch_taken_e = cond_ex_s & ctrl1_s[3];

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_n
//
// Directed self-checking bench for ctrl_pipe_n (STAGES=4, CTRL_W=12).
// Expected values are hand-computed constants. Define CTRL_PIPE_PERF_EN for
// both bench and design to exercise the performance counters.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_n;

    logic        clk;
    logic        reset;
    logic [11:0] ctrl_d;
    logic [3:0]  cond_d;
    logic        valid_d;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic [3:0]  alu_flags_e;
    logic [35:0] ctrl_q;
    logic [2:0]  valid_q;
    logic [3:0]  flags_q;
    logic        cond_ex_e;
    logic        branch_taken_e;
`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] perf_bubbles;
    logic [15:0] perf_condfail;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    ctrl_pipe_n #(.STAGES(4), .CTRL_W(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_d         (ctrl_d),
        .cond_d         (cond_d),
        .valid_d        (valid_d),
        .stall          (stall),
        .flush          (flush),
        .alu_flags_e    (alu_flags_e),
        .ctrl_q         (ctrl_q),
        .valid_q        (valid_q),
        .flags_q        (flags_q),
        .cond_ex_e      (cond_ex_e),
        .branch_taken_e (branch_taken_e)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .perf_bubbles   (perf_bubbles),
        .perf_condfail  (perf_condfail)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [11:0] slot(input int k);
        return ctrl_q[k*12-1 -: 12];
    endfunction

    // One rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] c, input logic [3:0] cc);
        valid_d = v;
        ctrl_d  = c;
        cond_d  = cc;
    endtask

    // Load NZCV through an AL instruction with both FlagWrite bits set.
    task automatic set_flags(input logic [3:0] nzcv);
        drive(1'b1, 12'h030, 4'b1110);
        step();
        alu_flags_e = nzcv;
        drive(1'b0, 12'h000, 4'b0000);
        step();
        alu_flags_e = 4'b0000;
        check_val("set_flags", 64'(flags_q), 64'(nzcv));
    endtask

    // Put a conditional branch in Execute and check the condition result.
    task automatic test_cond(input logic [3:0] cc, input logic exp);
        drive(1'b1, 12'h008, cc);
        step();
        check_val("cond_ex", 64'(cond_ex_e), 64'(exp));
        check_val("br_taken", 64'(branch_taken_e), 64'(exp));
        drive(1'b0, 12'h000, 4'b0000);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 3'b000;
        flush       = 3'b000;
        alu_flags_e = 4'b0000;
        drive(1'b1, 12'hFFF, 4'b1110);
        step();
        step();
        check_val("rst_valid", 64'(valid_q), 64'h0);
        check_val("rst_ctrl", 64'(ctrl_q), 64'h0);
        check_val("rst_flags", 64'(flags_q), 64'h0);
        check_val("rst_cond_ex", 64'(cond_ex_e), 64'h0);
        check_val("rst_branch", 64'(branch_taken_e), 64'h0);

        // Latency through the pipe with continuous valid input.
        reset = 1'b1;
        drive(1'b1, 12'h003, 4'b1110);
        step();
        check_val("lat_s1", 64'(slot(1)), 64'h003);
        check_val("lat_v1", 64'(valid_q), 64'h1);
        step();
        check_val("lat_s2", 64'(slot(2)), 64'h003);
        check_val("lat_v2", 64'(valid_q), 64'h3);
        step();
        check_val("lat_s3", 64'(slot(3)), 64'h003);
        check_val("lat_v3", 64'(valid_q), 64'h7);

        // Z=1 then NE fails, EQ passes.
        drive(1'b1, 12'h020, 4'b1110);
        step();
        alu_flags_e = 4'b0100;
        drive(1'b1, 12'h00F, 4'b0001);
        step();
        alu_flags_e = 4'b0000;
        check_val("flags_z", 64'(flags_q), 64'h4);
        check_val("ne_cond_ex", 64'(cond_ex_e), 64'h0);
        check_val("ne_branch", 64'(branch_taken_e), 64'h0);
        drive(1'b1, 12'h00F, 4'b0000);
        step();
        check_val("ne_gated_s2", 64'(slot(2)), 64'h008);
        check_val("eq_cond_ex", 64'(cond_ex_e), 64'h1);
        check_val("eq_branch", 64'(branch_taken_e), 64'h1);
        drive(1'b1, 12'h030, 4'b1110);
        step();
        check_val("eq_pass_s2", 64'(slot(2)), 64'h00F);

        // FlagWrite=11 then FlagWrite=01 (C,V only).
        alu_flags_e = 4'b1001;
        drive(1'b1, 12'h010, 4'b1110);
        step();
        check_val("flags_fw11", 64'(flags_q), 64'h9);
        alu_flags_e = 4'b0110;
        drive(1'b1, 12'h101, 4'b1110);
        step();
        check_val("flags_fw01", 64'(flags_q), 64'hA);
        alu_flags_e = 4'b0000;

        // Fill with X1,X2,X3 (X3 writes flags), then stall stage 2.
        drive(1'b1, 12'h102, 4'b1110);
        step();
        drive(1'b1, 12'h130, 4'b1110);
        step();
        check_val("fill_valid", 64'(valid_q), 64'h7);
        alu_flags_e = 4'b1111;
        stall       = 3'b010;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("stall_s1", 64'(slot(1)), 64'h130);
            check_val("stall_s2", 64'(slot(2)), 64'h102);
            check_val("stall_valid", 64'(valid_q), 64'h3);
            check_val("stall_flags", 64'(flags_q), 64'hA);
        end
        flush = 3'b010;
        step();
        check_val("sflush_valid", 64'(valid_q), 64'h1);
        check_val("sflush_s2", 64'(slot(2)), 64'h000);
        check_val("sflush_s1", 64'(slot(1)), 64'h130);
        check_val("sflush_flags", 64'(flags_q), 64'hA);
        stall = 3'b000;
        flush = 3'b000;
        drive(1'b1, 12'h101, 4'b1110);
        step();
        check_val("resume_flags", 64'(flags_q), 64'hF);
        check_val("resume_s2", 64'(slot(2)), 64'h130);
        check_val("resume_valid", 64'(valid_q), 64'h3);
        step();
        check_val("resume_s3", 64'(slot(3)), 64'h130);
        check_val("resume_v3", 64'(valid_q), 64'h7);

        // Asynchronous reset mid-stream, checked before any edge.
        alu_flags_e = 4'b0000;
        reset = 1'b0;
        #2;
        check_val("async_valid", 64'(valid_q), 64'h0);
        check_val("async_flags", 64'(flags_q), 64'h0);
        check_val("async_ctrl", 64'(ctrl_q), 64'h0);
        check_val("async_cond_ex", 64'(cond_ex_e), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 12'h0C1, 4'b1110);
        step();
        check_val("post_rst_s1", 64'(slot(1)), 64'h0C1);
        check_val("post_rst_v", 64'(valid_q), 64'h1);
        drive(1'b0, 12'h000, 4'b0000);

        // Condition-code table, flags = {N,Z,C,V}.
        set_flags(4'b0010);
        test_cond(4'b1000, 1'b1);
        test_cond(4'b1001, 1'b0);
        test_cond(4'b0010, 1'b1);
        test_cond(4'b0011, 1'b0);
        set_flags(4'b1000);
        test_cond(4'b1010, 1'b0);
        test_cond(4'b1011, 1'b1);
        test_cond(4'b1100, 1'b0);
        test_cond(4'b1101, 1'b1);
        test_cond(4'b0100, 1'b1);
        test_cond(4'b0101, 1'b0);
        set_flags(4'b1001);
        test_cond(4'b1010, 1'b1);
        test_cond(4'b1100, 1'b1);
        test_cond(4'b1101, 1'b0);
        test_cond(4'b0110, 1'b1);
        test_cond(4'b0111, 1'b0);
        set_flags(4'b0100);
        test_cond(4'b1001, 1'b1);
        test_cond(4'b1000, 1'b0);
        test_cond(4'b1100, 1'b0);
        test_cond(4'b1101, 1'b1);
        test_cond(4'b1111, 1'b0);
        test_cond(4'b1110, 1'b1);

`ifdef CTRL_PIPE_PERF_EN
        // Counters: 3 stage-1 flushes, 2 condition failures, then saturation.
        reset = 1'b0;
        flush = 3'b001;
        drive(1'b1, 12'h001, 4'b1110);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        flush = 3'b000;
        drive(1'b1, 12'h001, 4'b1111);
        step();
        step();
        drive(1'b0, 12'h000, 4'b0000);
        step();
        check_val("perf_bubbles", 64'(perf_bubbles), 64'd3);
        check_val("perf_condfail", 64'(perf_condfail), 64'd2);
        flush = 3'b001;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        flush = 3'b000;
        check_val("perf_bub_sat", 64'(perf_bubbles), 64'hFFFF);
        check_val("perf_cf_hold", 64'(perf_condfail), 64'd2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_n.md
# ctrl_pipe_n

Parametrised control-signal pipeline for the pipelined ARM core. It carries the decoded control bundle from Decode through STAGES-1 registered stages (Execute, Memory, Writeback, …). Each stage has its own stall and flush. It evaluates the ARM condition field in Execute against an internal NZCV register. It gates the side-effect bits of failed instructions and produces the Execute branch-taken strobe. It replaces the fixed three-register control chain and is driven by the decoder and the hazard unit.

## Interface
- `STAGES`, 4, total stages including Decode (stage 0); registered stages are 1..STAGES-1; legal range 3..8
- `CTRL_W`, 12, control bundle width; fixed layout: bit0 RegWrite, bit1 MemWrite, bit2 PCSrc, bit3 Branch, bit4 FlagWrite[0] (C,V), bit5 FlagWrite[1] (N,Z), bits CTRL_W-1:6 opaque payload (MemtoReg, ALUSrc, Brl, ALUControl…); legal minimum 6

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `ctrl_d`  in  CTRL_W  decoded bundle, stage 0
- `cond_d`  in  4  Instr[31:28], stage 0
- `valid_d`  in  1  stage 0 holds a real instruction
- `stall`  in  STAGES-1  bit k-1 = hold stage k
- `flush`  in  STAGES-1  bit k-1 = load bubble into stage k
- `alu_flags_e`  in  4  NZCV from the Execute ALU
- `ctrl_q`  out  CTRL_W*(STAGES-1)  stage k bundle at bits [k*CTRL_W-1 -: CTRL_W]
- `valid_q`  out  STAGES-1  bit k-1 = stage k valid
- `flags_q`  out  4  architectural NZCV register
- `cond_ex_e`  out  1  stage-1 instruction passes its condition
- `branch_taken_e`  out  1  valid_q[0] & Branch & cond_ex_e
- `perf_bubbles`, `perf_condfail`  out  16 each  present only with the macro below

## Operation
- Stage 1 holds the raw bundle plus `cond`. Stages 2..STAGES-1 hold the gated bundle.
- Condition codes follow ARM:
  - EQ/NE on Z; CS/CC on C; MI/PL on N; VS/VC on V
  - HI = C&!Z; LS = !C|Z
  - GE = N==V; LT = N!=V; GT = !Z&(N==V); LE = Z|(N!=V)
  - 1110 AL = true; 1111 = false
- `cond_ex_e` is evaluated combinationally from stage-1 `cond` and `flags_q`. It is forced 0 when stage 1 is invalid.
- Gating into stage 2: bits 0,1,2,4,5 are ANDed with `cond_ex_e`. Bit 3 and the payload pass unchanged. `valid` propagates unchanged, so a failed instruction still occupies its slot.
- Flags update: on the edge where stage 1 advances (not stalled) with `cond_ex_e`=1:
  - FlagWrite[1] loads N,Z from `alu_flags_e`
  - FlagWrite[0] loads C,V from `alu_flags_e`
  - Both bits may update together.
- Effective stall: stage k is held if `stall` of k or any later stage is set.
- Stage k next value, in priority order:
  1. `flush[k-1]` → bubble (valid 0, bundle 0)
  2. effective stall → hold
  3. stage k-1 effectively stalled while k is not → bubble
  4. otherwise load from stage k-1 (gated for k=2)
- Flush overrides stall on the same stage. A flushed stage-1 instruction never updates the flags.

## Timing
- Reset (async assert, synchronous-edge release): every `valid_q` bit 0, every `ctrl_q` bit 0, `flags_q`=0000, perf counters 0. `cond_ex_e` and `branch_taken_e` are therefore 0.
- Latency `ctrl_d` → stage k output: k cycles with no stalls.
- `branch_taken_e` and `cond_ex_e` are combinational within the stage-1 cycle.
- Updated flags are visible to the next stage-1 instruction one cycle later. There is no same-cycle bypass.
- Reset asserted mid-stream clears all stages immediately. The first valid instruction after release appears at stage 1 one edge after it is presented.

## Configuration
- `CTRL_PIPE_PERF_EN` defined:
  - `perf_bubbles` increments once per edge on which stage 1 loads a bubble because of flush or rule 3.
  - `perf_condfail` increments once per edge on which a valid stage-1 instruction with `cond_ex_e`=0 advances.
  - Both saturate at 16'hFFFF and reset to 0.
- Macro undefined: both ports and both counters are absent; all other behaviour is identical.

## Test plan
- STAGES=4: `valid_d`=1, `ctrl_d`=12'h003, `cond_d`=1110, no stalls → `ctrl_q` stage 1/2/3 equals 12'h003 at edges 1/2/3; `valid_q`=111 after edge 3.
- `flags_q`=0100 (Z=1):
  - stage-1 cond=0001 (NE), bundle 12'h00F → `cond_ex_e`=0, `branch_taken_e`=0, stage 2 bundle 12'h008
  - cond=0000 (EQ) → `branch_taken_e`=1, stage 2 bundle 12'h00F
- Stage 1 AL, FlagWrite=11, `alu_flags_e`=1001 → `flags_q`=1001 after edge. Repeat with FlagWrite=01 and `alu_flags_e`=0110 → `flags_q`=1010.
- `stall`=010 for 2 cycles → stages 1,2 hold, stage 3 shows valid 0 for 2 cycles, `flags_q` unchanged during stall; `stall`=010 with `flush`=010 → stage 2 becomes bubble.
- Reset pulsed low mid-stream with all stages valid → `valid_q`=000, `flags_q`=0000 without waiting for a clock edge.
- With `CTRL_PIPE_PERF_EN`: 3 flushes of stage 1 plus 2 cond-failed instructions → `perf_bubbles`=3, `perf_condfail`=2; force 70000 bubbles → `perf_bubbles`=16'hFFFF.
